mpmc10_req_strip_gen: RTL and testbench

Request-side strip issuer for the mpmc10 memory controller. It is the counterpart of the response strip counter that counts returning read strips. On a start pulse it latches a base address, direction and strip count. It then drives num_strips+1 single-beat commands onto the MIG app command interface, plus write-data beats on the app_wdf channel for writes. The controller FSM uses its done pulse to advance.

---
 rtl/mpmc10_req_strip_gen.sv | 153 +++++++++++++++
 tb/tb_mpmc10_req_strip_gen.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpmc10_req_strip_gen.sv
// mpmc10 request-side strip issuer.
// Drives num_strips+1 single-beat MIG commands, plus write beats for writes.
module mpmc10_req_strip_gen #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128,
    parameter int STRIP_BYTES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                we,
    input  logic [ADDR_W-1:0]   base_adr,
    input  logic [5:0]          num_strips,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wmask,
    input  logic                app_rdy,
    input  logic                app_wdf_rdy,
    output logic                app_en,
    output logic [2:0]          app_cmd,
    output logic [ADDR_W-1:0]   app_addr,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic [DATA_W/8-1:0] app_wdf_mask,
    output logic [5:0]          strip_cnt,
    output logic [5:0]          wstrip_cnt,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W-1:0] STRIP_INC  = ADDR_W'(STRIP_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STRIP_INC - 1'b1);

    typedef enum logic [1:0] {IDLE, ISSUE, FIN} state_t;

    state_t              state_q, state_d;
    logic [5:0]          num_q, num_d;
    logic                en_q, en_d;
    logic [2:0]          cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wren_q, wren_d;
    logic [5:0]          strip_q, strip_d;
    logic [5:0]          wstrip_q, wstrip_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cmd_done_q, cmd_done_d;
    logic                wr_done_q, wr_done_d;

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            num_q      <= '0;
            en_q       <= 1'b0;
            cmd_q      <= '0;
            addr_q     <= '0;
            wren_q     <= 1'b0;
            strip_q    <= '0;
            wstrip_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cmd_done_q <= 1'b0;
            wr_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            en_q       <= en_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wren_q     <= wren_d;
            strip_q    <= strip_d;
            wstrip_q   <= wstrip_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cmd_done_q <= cmd_done_d;
            wr_done_q  <= wr_done_d;
        end
    end

    // Next-state: latch on start, run both channels independently, pulse done.
    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        en_d       = en_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wren_d     = wren_q;
        strip_d    = strip_q;
        wstrip_d   = wstrip_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cmd_done_d = cmd_done_q;
        wr_done_d  = wr_done_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    num_d      = num_strips;
                    addr_d     = base_adr & ALIGN_MASK;
                    cmd_d      = we ? 3'b000 : 3'b001;
                    en_d       = 1'b1;
                    wren_d     = we;
                    strip_d    = '0;
                    wstrip_d   = '0;
                    busy_d     = 1'b1;
                    cmd_done_d = 1'b0;
                    wr_done_d  = ~we;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (en_q && app_rdy) begin
                    if (strip_q == num_q) begin
                        en_d       = 1'b0;
                        cmd_done_d = 1'b1;
                    end else begin
                        strip_d = strip_q + 6'd1;
                        addr_d  = addr_q + STRIP_INC;
                    end
                end
                if (wren_q && app_wdf_rdy) begin
                    if (wstrip_q == num_q) begin
                        wren_d    = 1'b0;
                        wr_done_d = 1'b1;
                    end else begin
                        wstrip_d = wstrip_q + 6'd1;
                    end
                end
                if (cmd_done_q && wr_done_q) state_d = FIN;
            end
            FIN: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                cmd_done_d = 1'b0;
                wr_done_d  = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign app_en       = en_q;
    assign app_cmd      = cmd_q;
    assign app_addr     = addr_q;
    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = wren_q;
    assign app_wdf_data = wdata;
    assign app_wdf_mask = wmask;
    assign strip_cnt    = strip_q;
    assign wstrip_cnt   = wstrip_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mpmc10_req_strip_gen.sv
// Directed bench for mpmc10_req_strip_gen.
// One task per scenario, inline comparisons.
module tb_mpmc10_req_strip_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         we;
    logic [31:0]  base_adr;
    logic [5:0]   num_strips;
    logic [127:0] wdata;
    logic [15:0]  wmask;
    logic         app_rdy;
    logic         app_wdf_rdy;
    logic         app_en;
    logic [2:0]   app_cmd;
    logic [31:0]  app_addr;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic [5:0]   strip_cnt;
    logic [5:0]   wstrip_cnt;
    logic         busy;
    logic         done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mpmc10_req_strip_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .we           (we),
        .base_adr     (base_adr),
        .num_strips   (num_strips),
        .wdata        (wdata),
        .wmask        (wmask),
        .app_rdy      (app_rdy),
        .app_wdf_rdy  (app_wdf_rdy),
        .app_en       (app_en),
        .app_cmd      (app_cmd),
        .app_addr     (app_addr),
        .app_wdf_wren (app_wdf_wren),
        .app_wdf_end  (app_wdf_end),
        .app_wdf_data (app_wdf_data),
        .app_wdf_mask (app_wdf_mask),
        .strip_cnt    (strip_cnt),
        .wstrip_cnt   (wstrip_cnt),
        .busy         (busy),
        .done         (done)
    );

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic w, input logic [31:0] a,
                               input logic [5:0] n);
        we = w;
        base_adr = a;
        num_strips = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        we = 1'b0;
        base_adr = '0;
        num_strips = '0;
        wdata = '0;
        wmask = '0;
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        tick();
        tick();
        checks++;
        if ({app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
             strip_cnt, wstrip_cnt, busy, done} !== 52'd0) begin
            failures++;
            $display("FAIL reset_state got en=%b cmd=%h addr=%h wren=%b sc=%0d wsc=%0d busy=%b done=%b expected all zero",
                     app_en, app_cmd, app_addr, app_wdf_wren,
                     strip_cnt, wstrip_cnt, busy, done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_burst();
        logic [31:0] exp_a;
        app_rdy = 1'b1;
        pulse_start(1'b0, 32'h1000, 6'd3);
        for (int i = 0; i < 4; i++) begin
            exp_a = 32'h1000 + 32'(16 * i);
            checks++;
            if (app_en !== 1'b1 || app_addr !== exp_a || app_cmd !== 3'b001
                || app_wdf_wren !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL read_issue[%0d] got en=%b addr=%h cmd=%h wren=%b busy=%b expected en=1 addr=%h cmd=1 wren=0 busy=1",
                         i, app_en, app_addr, app_cmd, app_wdf_wren, busy, exp_a);
            end
            tick();
        end
        checks++;
        if (app_en !== 1'b0 || strip_cnt !== 6'd3 || done !== 1'b0) begin
            failures++;
            $display("FAIL read_after_last got en=%b sc=%0d done=%b expected en=0 sc=3 done=0",
                     app_en, strip_cnt, done);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL read_done_early got done=%b expected 0", done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || strip_cnt !== 6'd3) begin
            failures++;
            $display("FAIL read_done got done=%b busy=%b sc=%0d expected done=1 busy=0 sc=3",
                     done, busy, strip_cnt);
        end
        tick();
        checks++;
        if (done !== 1'b0 || strip_cnt !== 6'd3) begin
            failures++;
            $display("FAIL read_done_pulse got done=%b sc=%0d expected done=0 sc=3",
                     done, strip_cnt);
        end
    endtask

    task automatic test_write_stall();
        wdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        wmask = 16'hA5C3;
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b1;
        pulse_start(1'b1, 32'h2000, 6'd1);
        checks++;
        if (app_en !== 1'b1 || app_cmd !== 3'b000 || app_addr !== 32'h2000
            || app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1
            || app_wdf_data !== wdata || app_wdf_mask !== 16'hA5C3) begin
            failures++;
            $display("FAIL write_first got en=%b cmd=%h addr=%h wren=%b end=%b mask=%h expected en=1 cmd=0 addr=2000 wren=1 end=1 mask=a5c3",
                     app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
                     app_wdf_mask);
        end
        tick();
        tick();
        tick();
        checks++;
        if (app_wdf_wren !== 1'b0 || wstrip_cnt !== 6'd1 || app_en !== 1'b1
            || app_addr !== 32'h2000 || strip_cnt !== 6'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL write_stall got wren=%b wsc=%0d en=%b addr=%h sc=%0d done=%b expected wren=0 wsc=1 en=1 addr=2000 sc=0 done=0",
                     app_wdf_wren, wstrip_cnt, app_en, app_addr, strip_cnt, done);
        end
        app_rdy = 1'b1;
        tick();
        checks++;
        if (app_en !== 1'b1 || app_addr !== 32'h2010 || strip_cnt !== 6'd1) begin
            failures++;
            $display("FAIL write_cmd2 got en=%b addr=%h sc=%0d expected en=1 addr=2010 sc=1",
                     app_en, app_addr, strip_cnt);
        end
        tick();
        checks++;
        if (app_en !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL write_cmd_end got en=%b done=%b expected en=0 done=0",
                     app_en, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL write_fin got done=%b busy=%b expected done=0 busy=1",
                     done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b1 || wstrip_cnt !== 6'd1 || strip_cnt !== 6'd1) begin
            failures++;
            $display("FAIL write_done got done=%b wsc=%0d sc=%0d expected done=1 wsc=1 sc=1",
                     done, wstrip_cnt, strip_cnt);
        end
        tick();
    endtask

    task automatic test_single_strip();
        app_rdy = 1'b1;
        pulse_start(1'b0, 32'h1007, 6'd0);
        checks++;
        if (app_en !== 1'b1 || app_addr !== 32'h1000) begin
            failures++;
            $display("FAIL single_issue got en=%b addr=%h expected en=1 addr=1000",
                     app_en, app_addr);
        end
        tick();
        checks++;
        if (app_en !== 1'b0 || strip_cnt !== 6'd0) begin
            failures++;
            $display("FAIL single_accept got en=%b sc=%0d expected en=0 sc=0",
                     app_en, strip_cnt);
        end
        tick();
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL single_done got done=%b expected 1", done);
        end
        tick();
    endtask

    task automatic test_wrap();
        app_rdy = 1'b1;
        pulse_start(1'b0, 32'hFFFF_FFF0, 6'd1);
        checks++;
        if (app_addr !== 32'hFFFF_FFF0) begin
            failures++;
            $display("FAIL wrap_first got addr=%h expected fffffff0", app_addr);
        end
        tick();
        checks++;
        if (app_addr !== 32'h0000_0000 || app_en !== 1'b1) begin
            failures++;
            $display("FAIL wrap_second got addr=%h en=%b expected addr=00000000 en=1",
                     app_addr, app_en);
        end
        tick();
        tick();
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL wrap_done got done=%b expected 1", done);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int seen_done;
        app_rdy = 1'b1;
        pulse_start(1'b0, 32'h5000, 6'd4);
        tick();
        tick();
        checks++;
        if (strip_cnt !== 6'd2 || app_addr !== 32'h5020) begin
            failures++;
            $display("FAIL midrst_pre got sc=%0d addr=%h expected sc=2 addr=5020",
                     strip_cnt, app_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({app_en, app_addr, strip_cnt, busy, done} !== 41'd0) begin
            failures++;
            $display("FAIL midrst_async got en=%b addr=%h sc=%0d busy=%b done=%b expected all zero",
                     app_en, app_addr, strip_cnt, busy, done);
        end
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) seen_done++;
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_nodone got done_count=%0d busy=%b expected 0 and 0",
                     seen_done, busy);
        end
        pulse_start(1'b0, 32'h3000, 6'd0);
        checks++;
        if (app_en !== 1'b1 || app_addr !== 32'h3000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_restart got en=%b addr=%h busy=%b expected en=1 addr=3000 busy=1",
                     app_en, app_addr, busy);
        end
        tick();
        tick();
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL midrst_restart_done got done=%b expected 1", done);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        app_rdy = 1'b1;
        pulse_start(1'b0, 32'h4000, 6'd2);
        we = 1'b1;
        base_adr = 32'h9000;
        num_strips = 6'd5;
        start = 1'b1;
        tick();
        checks++;
        if (app_addr !== 32'h4010 || app_wdf_wren !== 1'b0 || app_cmd !== 3'b001) begin
            failures++;
            $display("FAIL rebusy_1 got addr=%h wren=%b cmd=%h expected addr=4010 wren=0 cmd=1",
                     app_addr, app_wdf_wren, app_cmd);
        end
        tick();
        start = 1'b0;
        checks++;
        if (app_addr !== 32'h4020 || strip_cnt !== 6'd2) begin
            failures++;
            $display("FAIL rebusy_2 got addr=%h sc=%0d expected addr=4020 sc=2",
                     app_addr, strip_cnt);
        end
        tick();
        checks++;
        if (app_en !== 1'b0 || strip_cnt !== 6'd2) begin
            failures++;
            $display("FAIL rebusy_end got en=%b sc=%0d expected en=0 sc=2",
                     app_en, strip_cnt);
        end
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || strip_cnt !== 6'd2 || app_addr !== 32'h4020) begin
            failures++;
            $display("FAIL rebusy_done got done=%b sc=%0d addr=%h expected done=1 sc=2 addr=4020",
                     done, strip_cnt, app_addr);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write_stall();
        test_single_strip();
        test_wrap();
        test_reset_mid_burst();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
